boy_sprite_addr_gen: RTL and testbench
======================================

// Module: boy_sprite_addr_gen
// PURPOSE
//  Upstream feeder for the per-frame boy sprite ROM/palette stages. Per pixel, tests DrawX/DrawY
//  against the player's 20x40 bounding box. Generates the ROM address relative to that box.
//  Runs the walk-animation state machine that picks which frame ROM (stand/right/left) is read.
//  Outputs are registered on posedge vga_clk so the ROM can read on the following negedge.
// PARAMETERS
//  SPR_W            20  sprite width in pixels
//  SPR_H            40  sprite height in pixels
//  FRAMES_PER_STEP  8   video frames each walk image is held (>=1)
//  STEPS            2   walk images per direction (1..3)
// PORTS
//  vga_clk      in   1   pixel clock; all state on posedge
//  Reset        in   1   asynchronous, active-high reset
//  DrawX        in   10  current pixel column, 0..639
//  DrawY        in   10  current pixel row, 0..479
//  blank        in   1   1 = active video
//  frame_start  in   1   1-cycle pulse once per frame, during vertical blanking
//  BoyX         in   10  sprite top-left column
//  BoyY         in   10  sprite top-left row
//  moving       in   1   player is walking
//  dir_left     in   1   1 = facing left, 0 = facing right
//  rom_address  out  10  offset into the selected frame ROM, 0..SPR_W*SPR_H-1
//  sprite_sel   out  3   0 = STAND, 1..STEPS = RIGHT[step], STEPS+1..2*STEPS = LEFT[step]
//  in_sprite    out  1   pixel lies inside the box and blank=1
// BEHAVIOUR
//  Reset (async): rom_address=0, sprite_sel=0, in_sprite=0, state=IDLE, step=0, hold_cnt=0.
//  Box test:
//   - Compare with 11-bit sums: DrawX>=BoyX && DrawX<BoyX+SPR_W && DrawY>=BoyY && DrawY<BoyY+SPR_H.
//   - No wrap. A box extending past 639/479 is clipped, not folded.
//  Address: (DrawX-BoyX) + (DrawY-BoyY)*SPR_W when inside; 0 when outside.
//  Latency: exactly 1 cycle. Outputs at posedge N+1 reflect DrawX/DrawY/BoyX/BoyY/blank sampled at posedge N.
//  in_sprite = box_hit & blank, registered on the same edge as rom_address.
//  Animation FSM states: IDLE, WALK_R, WALK_L. The FSM advances only on cycles with frame_start=1.
//   - Any state, moving=0 at frame_start -> IDLE, step=0, hold_cnt=0.
//   - moving=1, dir_left=0 -> WALK_R. moving=1, dir_left=1 -> WALK_L.
//   - Entering a walk state from a different state (including a direction flip): step=0, hold_cnt=0.
//   - Staying in the same walk state: hold_cnt++.
//     When hold_cnt reaches FRAMES_PER_STEP-1, it clears and step = (step==STEPS-1) ? 0 : step+1.
//   - sprite_sel is registered from state/step: IDLE=0, WALK_R=1+step, WALK_L=1+STEPS+step.
//   - sprite_sel changes only on the cycle after frame_start, so a visible frame never tears mid-frame.
//  moving/dir_left changes between frame_start pulses are ignored; only the value at frame_start counts.
//  frame_start while blank=1 does not occur (upstream contract). No checking is required.
//  Reset asserted mid-frame or mid-walk forces IDLE/sel 0 immediately.
//  After release, the first frame_start re-evaluates the inputs.
// TESTING
//  - Reset: assert Reset mid-walk (sel=4) -> all outputs 0 the same cycle. First frame_start after release with moving=0 keeps sel=0.
//  - Address corners: BoyX=100, BoyY=200.
//    (100,200) -> addr 0, in_sprite 1. (119,239) -> addr 799. (120,200) -> in_sprite 0, addr 0.
//    (99,239) -> in_sprite 0. All results appear 1 cycle after the input.
//  - Blank masking: pixel inside the box with blank=0 -> in_sprite 0, addr still computed.
//  - Walk right, FRAMES_PER_STEP=4, STEPS=2, moving=1, dir_left=0: sel per frame_start is 1,1,1,1,2,2,2,2,1... (wraps).
//  - Direction flip at step=1: dir_left 0->1 -> next sel=3 (LEFT step 0).
//    moving=0 at the next frame_start -> sel=0.
//  - Clipping: BoyX=630, DrawX=639 -> in_sprite 1, addr col 9. DrawX=0 on the same row -> in_sprite 0 (no wrap).

Source files
------------

// File: rtl/boy_sprite_addr_gen.sv
// Boy sprite address generator: bounding-box test, ROM offset and
// walk-animation frame selection, all registered on the pixel clock.
module boy_sprite_addr_gen #(
    parameter int SPR_W           = 20,
    parameter int SPR_H           = 40,
    parameter int FRAMES_PER_STEP = 8,
    parameter int STEPS           = 2
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       frame_start,
    input  logic [9:0] BoyX,
    input  logic [9:0] BoyY,
    input  logic       moving,
    input  logic       dir_left,
    output logic [9:0] rom_address,
    output logic [2:0] sprite_sel,
    output logic       in_sprite
);

    localparam int HW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(FRAMES_PER_STEP - 1);
    localparam logic [1:0]    STEP_MAX = 2'(STEPS - 1);
    localparam logic [9:0]    W10      = 10'(SPR_W);
    localparam logic [2:0]    LEFT0    = 3'(1 + STEPS);

    typedef enum logic [1:0] {IDLE, WALK_R, WALK_L} state_t;

    state_t        state_q, state_d, tgt;
    logic [1:0]    step_q, step_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [2:0]    sel_q, sel_d;
    logic [9:0]    addr_q, addr_d;
    logic          in_q, in_d;

    logic [10:0] x_end, y_end;
    logic [9:0]  dx, dy;
    logic        hit;

    // 11-bit box ends so a sprite near the right/bottom edge clips instead of wrapping
    assign x_end = {1'b0, BoyX} + 11'(SPR_W);
    assign y_end = {1'b0, BoyY} + 11'(SPR_H);
    assign hit   = (DrawX >= BoyX) && ({1'b0, DrawX} < x_end) &&
                   (DrawY >= BoyY) && ({1'b0, DrawY} < y_end);
    assign dx    = DrawX - BoyX;
    assign dy    = DrawY - BoyY;

    always_comb begin
        addr_d = hit ? (dx + dy * W10) : '0;
        in_d   = hit & blank;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        tgt     = dir_left ? WALK_L : WALK_R;
        if (frame_start) begin
            if (!moving) begin
                state_d = IDLE;
                step_d  = '0;
                hold_d  = '0;
            end else if (tgt != state_q) begin
                state_d = tgt;
                step_d  = '0;
                hold_d  = '0;
            end else if (hold_q == HOLD_MAX) begin
                hold_d = '0;
                step_d = (step_q == STEP_MAX) ? 2'd0 : step_q + 2'd1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        sel_d = 3'd0;
        unique case (state_d)
            IDLE:    sel_d = 3'd0;
            WALK_R:  sel_d = 3'd1 + {1'b0, step_d};
            WALK_L:  sel_d = LEFT0 + {1'b0, step_d};
            default: sel_d = 3'd0;
        endcase
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            in_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            in_q    <= in_d;
        end
    end

    assign rom_address = addr_q;
    assign sprite_sel  = sel_q;
    assign in_sprite   = in_q;

endmodule

// File: tb/tb_boy_sprite_addr_gen.sv
// Bench for boy_sprite_addr_gen: per-cycle compare against an arithmetic
// model, plus directed literal checks on address corners and animation.
module tb_boy_sprite_addr_gen;

    localparam int W   = 20;
    localparam int H   = 40;
    localparam int FPS = 4;
    localparam int ST  = 2;

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       blank = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] BoyX = 10'd100, BoyY = 10'd200;
    logic       moving = 1'b0, dir_left = 1'b0;
    logic [9:0] rom_address;
    logic [2:0] sprite_sel;
    logic       in_sprite;

    int checks = 0;
    int errors = 0;

    boy_sprite_addr_gen #(
        .SPR_W(W), .SPR_H(H), .FRAMES_PER_STEP(FPS), .STEPS(ST)
    ) dut (
        .vga_clk(vga_clk), .Reset(Reset),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .frame_start(frame_start), .BoyX(BoyX), .BoyY(BoyY),
        .moving(moving), .dir_left(dir_left),
        .rom_address(rom_address), .sprite_sel(sprite_sel),
        .in_sprite(in_sprite)
    );

    always #5 vga_clk = ~vga_clk;

    // Model: walk image = (frame_starts since entering direction / FPS) mod ST
    int cur = 0;
    int n = 0;
    int exp_addr = 0, exp_in = 0, exp_sel = 0;

    always @(posedge vga_clk or posedge Reset) begin
        int x, y, bx, by, tg;
        bit hit;
        if (Reset) begin
            cur = 0; n = 0;
            exp_addr = 0; exp_in = 0; exp_sel = 0;
        end else begin
            x = DrawX; y = DrawY; bx = BoyX; by = BoyY;
            hit = (x >= bx) && (x < bx + W) && (y >= by) && (y < by + H);
            exp_addr = hit ? (x - bx) + (y - by) * W : 0;
            exp_in = (hit && blank) ? 1 : 0;
            if (frame_start) begin
                if (!moving) begin
                    cur = 0; n = 0;
                end else begin
                    tg = dir_left ? 2 : 1;
                    if (tg != cur) begin
                        cur = tg; n = 0;
                    end else begin
                        n = n + 1;
                    end
                end
            end
            if (cur == 0) exp_sel = 0;
            else exp_sel = ((cur == 1) ? 1 : 1 + ST) + (n / FPS) % ST;
        end
    end

    always @(negedge vga_clk) begin
        checks++;
        if (rom_address !== 10'(exp_addr) || in_sprite !== exp_in[0] ||
            sprite_sel !== 3'(exp_sel)) begin
            errors++;
            $display("FAIL model t=%0t addr=%0d/%0d in=%0b/%0d sel=%0d/%0d",
                     $time, rom_address, exp_addr, in_sprite, exp_in,
                     sprite_sel, exp_sel);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input bit bl,
                       input int ea, input int ei, input string nm);
        DrawX = 10'(x); DrawY = 10'(y); blank = bl;
        @(posedge vga_clk); #1;
        chk({nm, "_addr"}, int'(rom_address), ea);
        chk({nm, "_in"}, int'(in_sprite), ei);
    endtask

    task automatic fs(input bit mv, input bit dl, input int es, input string nm);
        blank = 1'b0;
        frame_start = 1'b1; moving = mv; dir_left = dl;
        @(posedge vga_clk); #1;
        frame_start = 1'b0;
        chk(nm, int'(sprite_sel), es);
        for (int i = 0; i < 3; i++) begin
            moving = ~moving; dir_left = ~dir_left;
            @(posedge vga_clk); #1;
        end
        chk({nm, "_hold"}, int'(sprite_sel), es);
    endtask

    initial begin
        int wr[9];
        wr = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        repeat (2) @(posedge vga_clk);
        #1;
        chk("rst_addr", int'(rom_address), 0);
        chk("rst_sel", int'(sprite_sel), 0);
        chk("rst_in", int'(in_sprite), 0);
        Reset = 1'b0;
        @(posedge vga_clk); #1;

        pix(100, 200, 1, 0, 1, "tl");
        pix(119, 239, 1, 799, 1, "br");
        pix(120, 200, 1, 0, 0, "right_out");
        pix(99, 239, 1, 0, 0, "left_out");
        pix(105, 210, 0, 205, 0, "blankmask");
        pix(110, 201, 1, 30, 1, "mid");
        BoyX = 10'd630;
        pix(639, 205, 1, 109, 1, "clip_in");
        pix(0, 205, 1, 0, 0, "clip_nowrap");
        BoyX = 10'd100;

        for (int i = 0; i < 9; i++) fs(1, 0, wr[i], $sformatf("walkr%0d", i));
        fs(1, 0, 1, "walkr9");
        fs(1, 0, 1, "walkr10");
        fs(1, 0, 1, "walkr11");
        fs(1, 0, 2, "walkr12");
        fs(1, 1, 3, "flip");
        fs(0, 0, 0, "stop");

        fs(1, 1, 3, "walkl0");
        fs(1, 1, 3, "walkl1");
        fs(1, 1, 3, "walkl2");
        fs(1, 1, 3, "walkl3");
        fs(1, 1, 4, "walkl4");
        DrawX = 10'd110; DrawY = 10'd210; blank = 1'b1;
        @(posedge vga_clk); #1;
        chk("pre_rst_in", int'(in_sprite), 1);
        chk("pre_rst_addr", int'(rom_address), 210);
        #2 Reset = 1'b1;
        #1;
        chk("mid_rst_sel", int'(sprite_sel), 0);
        chk("mid_rst_addr", int'(rom_address), 0);
        chk("mid_rst_in", int'(in_sprite), 0);
        @(posedge vga_clk); #1;
        Reset = 1'b0;
        @(posedge vga_clk); #1;
        fs(0, 0, 0, "post_rst_idle");
        fs(1, 0, 1, "post_rst_walk");
        repeat (2) @(posedge vga_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
